// File: rtl/uart_matrix_pkg.sv
// Shared types and defaults for the UART-driven 2x2 matrix controller.
// Holds the FSM state encoding, frame/timeout defaults and the result width.
package uart_matrix_pkg;

    localparam int N_ELEM_DEF      = 4;
    localparam int TIMEOUT_CYC_DEF = 43400;
    localparam int RES_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_READ    = 3'd4,
        ST_CAPT    = 3'd5,
        ST_SEND_HI = 3'd6,
        ST_SEND_LO = 3'd7
    } state_t;

    // Framing states accept RX bytes; every other state counts as busy.
    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_LOAD));
    endfunction

endpackage

// File: rtl/uart_matrix_timeout.sv
// Idle counter for inter-byte gaps: cleared on each byte, fires one pulse
// when LIMIT consecutive idle cycles have elapsed while enabled.
module uart_matrix_timeout #(
    parameter int LIMIT = 43400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Idle-cycle counter; wraps to zero on expiry so the pulse is single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear || !enable) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign expire = enable && !clear && (cnt_r == LAST);

endmodule

// File: rtl/uart_matrix_ctrl.sv
// Frames RX bytes into the operand buffer, kicks the matrix engine and
// streams the 16-bit results back out as big-endian TX byte pairs.
module uart_matrix_ctrl
    import uart_matrix_pkg::*;
#(
    parameter int N_ELEM      = N_ELEM_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      mat_wr_en,
    output logic [$clog2(N_ELEM)-1:0] mat_wr_addr,
    output logic [7:0]                mat_wr_data,
    output logic                      eng_start,
    input  logic                      eng_done,
    output logic [$clog2(N_ELEM)-1:0] res_rd_addr,
    input  logic [RES_W-1:0]          res_rd_data,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_drop
);

    localparam int AW = $clog2(N_ELEM);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_ELEM - 1);

    state_t             state_r, state_n;
    logic [AW-1:0]      elem_cnt_r, elem_cnt_n;
    logic [AW-1:0]      res_idx_r, res_idx_n;
    logic [RES_W-1:0]   result_r;
    logic               err_timeout_r, err_drop_r;
    logic               wr_en_s, tmo_en_s, tmo_clr_s, tmo_fire_s, expire_s, capt_s;
    logic [AW-1:0]      wr_addr_s;
    logic [7:0]         wr_data_s, tx_data_s;

    uart_matrix_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (tmo_en_s),
        .clear  (tmo_clr_s),
        .expire (expire_s)
    );

    // Next-state, buffer-write and counter-update logic.
    always_comb begin
        state_n    = state_r;
        elem_cnt_n = elem_cnt_r;
        res_idx_n  = res_idx_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = '0;
        wr_data_s  = 8'h00;
        tmo_en_s   = 1'b0;
        tmo_clr_s  = 1'b0;
        tmo_fire_s = 1'b0;
        capt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    wr_en_s    = 1'b1;
                    wr_data_s  = rx_data;
                    elem_cnt_n = AW'(1);
                    tmo_clr_s  = 1'b1;
                    state_n    = ST_LOAD;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tmo_en_s = 1'b1;
                if (rx_valid) begin
                    tmo_clr_s = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = elem_cnt_r;
                    wr_data_s = rx_data;
                    if (elem_cnt_r == LAST_IDX) begin
                        elem_cnt_n = '0;
                        state_n    = ST_START;
                    end else begin
                        elem_cnt_n = elem_cnt_r + AW'(1);
                    end
                end else if (expire_s) begin
                    // Partial frame dropped; the buffer keeps its stale contents.
                    tmo_fire_s = 1'b1;
                    elem_cnt_n = '0;
                    state_n    = ST_IDLE;
                end else begin
                    state_n    = ST_LOAD;
                end
            end
            ST_START: state_n = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    state_n = ST_READ;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_READ: state_n = ST_CAPT;
            ST_CAPT: begin
                capt_s  = 1'b1;
                state_n = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (tx_ready) begin
                    state_n = ST_SEND_LO;
                end else begin
                    state_n = ST_SEND_HI;
                end
            end
            ST_SEND_LO: begin
                if (tx_ready) begin
                    if (res_idx_r == LAST_IDX) begin
                        res_idx_n = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        res_idx_n = res_idx_r + AW'(1);
                        state_n   = ST_READ;
                    end
                end else begin
                    state_n = ST_SEND_LO;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // TX byte selection from the captured result word.
    always_comb begin
        case (state_r)
            ST_SEND_HI: tx_data_s = result_r[RES_W-1 -: 8];
            ST_SEND_LO: tx_data_s = result_r[7:0];
            default:    tx_data_s = 8'h00;
        endcase
    end

    // State, counters, result capture and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            elem_cnt_r    <= '0;
            res_idx_r     <= '0;
            result_r      <= '0;
            err_timeout_r <= 1'b0;
            err_drop_r    <= 1'b0;
        end else begin
            state_r       <= state_n;
            elem_cnt_r    <= elem_cnt_n;
            res_idx_r     <= res_idx_n;
            err_timeout_r <= tmo_fire_s;
            err_drop_r    <= err_drop_r | (rx_valid && is_busy(state_r));
            if (capt_s) begin
                result_r <= res_rd_data;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign mat_wr_en   = wr_en_s;
    assign mat_wr_addr = wr_addr_s;
    assign mat_wr_data = wr_data_s;
    assign eng_start   = (state_r == ST_START);
    assign res_rd_addr = res_idx_r;
    assign tx_valid    = (state_r == ST_SEND_HI) || (state_r == ST_SEND_LO);
    assign tx_data     = tx_data_s;
    assign busy        = is_busy(state_r);
    assign err_timeout = err_timeout_r;
    assign err_drop    = err_drop_r;

endmodule

// File: doc/uart_matrix_ctrl.md
UART_MATRIX_CTRL -- requirements
Module: uart_matrix_ctrl

Interface
REQ-001 Parameter N_ELEM, default 4, number of matrix elements per frame (2x2).
REQ-002 Parameter TIMEOUT_CYC, default 43400, max idle cycles between RX bytes of one frame.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle strobe, byte received from UART RX.
REQ-006 rx_data  input  8  received byte, valid with rx_valid.
REQ-007 mat_wr_en / mat_wr_addr / mat_wr_data  output  1 / $clog2(N_ELEM) / 8  operand-buffer write port.
REQ-008 eng_start  output  1  one-cycle start pulse to the matrix engine.
REQ-009 eng_done  input  1  one-cycle completion pulse from the engine.
REQ-010 res_rd_addr  output  $clog2(N_ELEM)  result-buffer read address.
REQ-011 res_rd_data  input  16  result word, valid one cycle after res_rd_addr.
REQ-012 tx_valid / tx_data / tx_ready  output / output / input  1 / 8 / 1  byte stream to UART TX.
REQ-013 busy  output  1  high in any state other than IDLE and LOAD.
REQ-014 err_timeout  output  1  one-cycle pulse on partial-frame discard.
REQ-015 err_drop  output  1  sticky, set when an RX byte is discarded while busy; cleared only by reset.

Function
REQ-016 States: IDLE, LOAD, START, WAIT, READ, CAPT, SEND_HI, SEND_LO.
REQ-017 IDLE: rx_valid -> write byte to addr 0 the same cycle (mat_wr_en=1), elem_cnt=1, go to LOAD.
REQ-018 LOAD: each rx_valid -> write to addr elem_cnt, increment elem_cnt; after write of addr N_ELEM-1 -> START.
REQ-019 LOAD: idle counter resets on each rx_valid; reaches TIMEOUT_CYC -> pulse err_timeout, elem_cnt=0, -> IDLE; written elements are not cleared.
REQ-020 START: eng_start=1 for exactly one cycle, -> WAIT.
REQ-021 WAIT: hold until eng_done; eng_done outside WAIT is ignored.
REQ-022 READ: drive res_rd_addr=res_idx, -> CAPT; CAPT: register res_rd_data, -> SEND_HI.
REQ-023 SEND_HI: tx_valid=1, tx_data=result[15:8]; on tx_valid&&tx_ready -> SEND_LO.
REQ-024 SEND_LO: tx_data=result[7:0]; on handshake, res_idx==N_ELEM-1 -> IDLE with res_idx=0, else res_idx+1 -> READ.
REQ-025 tx_data stable and tx_valid held while tx_ready low; tx_valid never drops without a handshake.
REQ-026 rx_valid in START, WAIT, READ, CAPT, SEND_HI or SEND_LO: byte discarded, no write, err_drop set.
REQ-027 Frame latency: eng_start asserts one cycle after the last element write.
REQ-028 No internal wait on eng_done: engine fault blocks in WAIT until reset.

Reset
REQ-029 On rst_n low, state=IDLE, counters=0, result reg=0, all outputs 0 (tx_valid, eng_start, mat_wr_en, err_* low), regardless of state.
REQ-030 Reset deassertion mid-frame restarts framing from element 0; no partial TX byte is completed.

Structure
REQ-031 State enum, N_ELEM default, TIMEOUT_CYC default and result width (16) in shared package uart_matrix_pkg.
REQ-032 One sub-module: uart_matrix_timeout (loadable idle counter with expiry pulse).

Verification
REQ-033 RX 0x01,0x02,0x03,0x04 gap 8680 cycles -> writes addr0..3 = 1..4, one eng_start; engine returns [7,10,15,22] -> TX 00 07 00 0A 00 0F 00 16, then busy=0.
REQ-034 RX 0x05,0x06 then 43400 idle cycles -> single err_timeout pulse, IDLE; then RX 1,2,3,4 -> writes addr0..3 correctly.
REQ-035 tx_ready low 10 cycles during SEND_HI -> tx_valid=1, tx_data=0x00 stable, no byte lost or duplicated.
REQ-036 RX 0xAA during WAIT -> no mat_wr_en, err_drop=1 and stays 1 after completion.
REQ-037 rst_n low during SEND_LO of element 2 -> next cycle all outputs 0, state IDLE; new 4-byte frame processes normally.
REQ-038 eng_done pulsed in IDLE -> ignored, no TX activity.
